// File: rtl/pkt_pkg.sv
// pkt_pkg: shared state encodings, error bit indices and byte width for pkt_stat
package pkt_pkg;
    typedef enum logic {IDLE = 1'b0, RX = 1'b1} state_t;
    localparam int ERR_SOP = 0;
    localparam int ERR_LEN = 1;
    localparam int ERR_TMO = 2;
    localparam int BYTE_W = 8;
endpackage

// File: rtl/pkt_gap_tmr.sv
// pkt_gap_tmr: idle-gap counter; expire fires on the cycle the gap reaches TMO_CYC
module pkt_gap_tmr #(
    parameter int TMO_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);
    logic [7:0] cnt;
    assign expire = inc && cnt == 8'(TMO_CYC - 1);
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/pkt_stat.sv
// pkt_stat: per-packet length, byte sum and framing-error summary
// Optional PKT_STAT_CNT_EN adds pkt_cnt, a count of error-free reports.
module pkt_stat
    import pkt_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAX_LEN = 64,
    parameter int TMO_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] din,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic              din_vld,
    output logic              stat_vld,
    output logic [LEN_W-1:0]  stat_len,
    output logic [BYTE_W-1:0] stat_sum,
    output logic [2:0]        stat_err,
    output logic              drop_pls
`ifdef PKT_STAT_CNT_EN
    ,
    output logic [15:0]       pkt_cnt
`endif
);
    state_t state, state_n;
    logic [LEN_W-1:0] len, len_n, len_upd, rpt_len;
    logic [BYTE_W-1:0] sum, sum_n, sum_upd, rpt_sum;
    logic [2:0] err, err_n, rpt_err;
    logic rpt, drop, inc, clr, expire, over;

    pkt_gap_tmr #(.TMO_CYC(TMO_CYC)) u_gap (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .inc(inc),
        .expire(expire)
    );

    assign clr     = state == IDLE || din_vld;
    assign len_upd = &len ? len : len + 1'b1;
    assign sum_upd = sum + din;
    assign over    = int'(len_upd) > MAX_LEN;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // A sop while a packet is open closes it as truncated; if that sop beat is
    // also eop the would-be single-byte packet is dropped instead of reported.
    always_comb begin
        state_n = state;
        len_n   = len;
        sum_n   = sum;
        err_n   = err;
        rpt     = 1'b0;
        rpt_len = len;
        rpt_sum = sum;
        rpt_err = err;
        drop    = 1'b0;
        inc     = 1'b0;
        if (state == IDLE) begin
            if (din_vld && din_sop) begin
                len_n   = LEN_W'(1);
                sum_n   = din;
                err_n   = '0;
                rpt     = din_eop;
                rpt_len = LEN_W'(1);
                rpt_sum = din;
                rpt_err = '0;
                state_n = din_eop ? IDLE : RX;
            end else
                drop = din_vld;
        end else if (din_vld && din_sop) begin
            rpt              = 1'b1;
            rpt_err[ERR_SOP] = 1'b1;
            len_n            = LEN_W'(1);
            sum_n            = din;
            err_n            = '0;
            drop             = din_eop;
            state_n          = din_eop ? IDLE : RX;
        end else if (din_vld) begin
            len_n          = len_upd;
            sum_n          = sum_upd;
            err_n[ERR_LEN] = err[ERR_LEN] | over;
            rpt            = din_eop;
            rpt_len        = len_upd;
            rpt_sum        = sum_upd;
            rpt_err        = err_n;
            state_n        = din_eop ? IDLE : RX;
        end else begin
            inc              = 1'b1;
            rpt              = expire;
            rpt_err[ERR_TMO] = 1'b1;
            state_n          = expire ? IDLE : RX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len      <= '0;
            sum      <= '0;
            err      <= '0;
            stat_vld <= 1'b0;
            stat_len <= '0;
            stat_sum <= '0;
            stat_err <= '0;
            drop_pls <= 1'b0;
        end else begin
            len      <= len_n;
            sum      <= sum_n;
            err      <= err_n;
            stat_vld <= rpt;
            drop_pls <= drop;
            if (rpt) begin
                stat_len <= rpt_len;
                stat_sum <= rpt_sum;
                stat_err <= rpt_err;
            end
        end
    end

`ifdef PKT_STAT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            pkt_cnt <= '0;
        else if (rpt && rpt_err == 3'b000)
            pkt_cnt <= pkt_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pkt_stat.sv
// tb_pkt_stat: directed checks of pkt_stat reports, drops, timeout, saturation and reset
module tb_pkt_stat;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] din = '0;
    logic din_sop = 1'b0, din_eop = 1'b0, din_vld = 1'b0;
    logic stat_vld, drop_pls, stat_vld6, drop_pls6;
    logic [7:0] stat_len, stat_sum, stat_sum6;
    logic [5:0] stat_len6;
    logic [2:0] stat_err, stat_err6;
    logic [20:0] rec, exp_rec;
    int vectors = 0;
    int fails = 0;
`ifdef PKT_STAT_CNT_EN
    logic [15:0] pkt_cnt, pkt_cnt6;
`endif

    always #5 clk = ~clk;

    pkt_stat dut (
        .clk(clk), .rst(rst), .din(din), .din_sop(din_sop), .din_eop(din_eop), .din_vld(din_vld),
        .stat_vld(stat_vld), .stat_len(stat_len), .stat_sum(stat_sum), .stat_err(stat_err),
        .drop_pls(drop_pls)
`ifdef PKT_STAT_CNT_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );

    pkt_stat #(.LEN_W(6)) dut6 (
        .clk(clk), .rst(rst), .din(din), .din_sop(din_sop), .din_eop(din_eop), .din_vld(din_vld),
        .stat_vld(stat_vld6), .stat_len(stat_len6), .stat_sum(stat_sum6), .stat_err(stat_err6),
        .drop_pls(drop_pls6)
`ifdef PKT_STAT_CNT_EN
        , .pkt_cnt(pkt_cnt6)
`endif
    );

    assign rec = {stat_vld, drop_pls, stat_len, stat_sum, stat_err};

    task automatic beat(input logic [7:0] d, input logic s, input logic e, input logic v);
        @(negedge clk);
        din = d;
        din_sop = s;
        din_eop = e;
        din_vld = v;
    endtask

    task automatic idle();
        beat(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (rec !== 21'h0) begin fails++; $display("FAIL reset got %h exp %h", rec, 21'h0); end
`ifdef PKT_STAT_CNT_EN
        vectors++;
        if (pkt_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", pkt_cnt); end
`endif
    endtask

    task automatic test_basic();
        beat(8'h01, 1, 0, 1);
        beat(8'h02, 0, 0, 1);
        beat(8'h03, 0, 0, 1);
        beat(8'h04, 0, 1, 1);
        idle();
        exp_rec = {1'b1, 1'b0, 8'd4, 8'h0a, 3'b000};
        vectors++;
        if (rec !== exp_rec) begin fails++; $display("FAIL basic got %h exp %h", rec, exp_rec); end
        idle();
        exp_rec = {1'b0, 1'b0, 8'd4, 8'h0a, 3'b000};
        vectors++;
        if (rec !== exp_rec) begin fails++; $display("FAIL basic_hold got %h exp %h", rec, exp_rec); end
    endtask

    task automatic test_single_orphan();
        beat(8'hff, 1, 1, 1);
        idle();
        exp_rec = {1'b1, 1'b0, 8'd1, 8'hff, 3'b000};
        vectors++;
        if (rec !== exp_rec) begin fails++; $display("FAIL single got %h exp %h", rec, exp_rec); end
        beat(8'h55, 0, 0, 1);
        idle();
        exp_rec = {1'b0, 1'b1, 8'd1, 8'hff, 3'b000};
        vectors++;
        if (rec !== exp_rec) begin fails++; $display("FAIL orphan got %h exp %h", rec, exp_rec); end
        idle();
        exp_rec = {1'b0, 1'b0, 8'd1, 8'hff, 3'b000};
        vectors++;
        if (rec !== exp_rec) begin fails++; $display("FAIL orphan_end got %h exp %h", rec, exp_rec); end
    endtask

    task automatic test_truncate();
        beat(8'h10, 1, 0, 1);
        beat(8'h20, 0, 0, 1);
        beat(8'h30, 1, 0, 1);
        beat(8'h40, 0, 1, 1);
        exp_rec = {1'b1, 1'b0, 8'd2, 8'h30, 3'b001};
        vectors++;
        if (rec !== exp_rec) begin fails++; $display("FAIL trunc_first got %h exp %h", rec, exp_rec); end
        idle();
        exp_rec = {1'b1, 1'b0, 8'd2, 8'h70, 3'b000};
        vectors++;
        if (rec !== exp_rec) begin fails++; $display("FAIL trunc_second got %h exp %h", rec, exp_rec); end
        beat(8'haa, 1, 0, 1);
        beat(8'hbb, 1, 1, 1);
        idle();
        exp_rec = {1'b1, 1'b1, 8'd1, 8'haa, 3'b001};
        vectors++;
        if (rec !== exp_rec) begin fails++; $display("FAIL trunc_drop got %h exp %h", rec, exp_rec); end
        beat(8'hcc, 0, 0, 1);
        idle();
        exp_rec = {1'b0, 1'b1, 8'd1, 8'haa, 3'b001};
        vectors++;
        if (rec !== exp_rec) begin fails++; $display("FAIL trunc_idle got %h exp %h", rec, exp_rec); end
    endtask

    task automatic test_back_to_back();
        beat(8'h11, 1, 1, 1);
        beat(8'h22, 1, 1, 1);
        exp_rec = {1'b1, 1'b0, 8'd1, 8'h11, 3'b000};
        vectors++;
        if (rec !== exp_rec) begin fails++; $display("FAIL b2b_first got %h exp %h", rec, exp_rec); end
        idle();
        exp_rec = {1'b1, 1'b0, 8'd1, 8'h22, 3'b000};
        vectors++;
        if (rec !== exp_rec) begin fails++; $display("FAIL b2b_second got %h exp %h", rec, exp_rec); end
    endtask

    task automatic test_timeout();
        beat(8'h01, 1, 0, 1);
        beat(8'h02, 0, 0, 1);
        for (int k = 0; k < 16; k++) begin
            idle();
            vectors++;
            if (stat_vld !== 1'b0) begin fails++; $display("FAIL tmo_early idle=%0d got %b exp 0", k, stat_vld); end
        end
        idle();
        exp_rec = {1'b1, 1'b0, 8'd2, 8'h03, 3'b100};
        vectors++;
        if (rec !== exp_rec) begin fails++; $display("FAIL tmo got %h exp %h", rec, exp_rec); end
        beat(8'h77, 0, 1, 1);
        idle();
        exp_rec = {1'b0, 1'b1, 8'd2, 8'h03, 3'b100};
        vectors++;
        if (rec !== exp_rec) begin fails++; $display("FAIL tmo_orphan got %h exp %h", rec, exp_rec); end
    endtask

    task automatic test_overlength();
        beat(8'h01, 1, 0, 1);
        repeat (68) beat(8'h01, 0, 0, 1);
        beat(8'h01, 0, 1, 1);
        idle();
        exp_rec = {1'b1, 1'b0, 8'd70, 8'h46, 3'b010};
        vectors++;
        if (rec !== exp_rec) begin fails++; $display("FAIL overlen got %h exp %h", rec, exp_rec); end
        vectors++;
        if ({stat_vld6, stat_len6, stat_sum6} !== {1'b1, 6'd63, 8'h46}) begin
            fails++;
            $display("FAIL len_sat got vld=%b len=%0d sum=%h exp vld=1 len=63 sum=46", stat_vld6, stat_len6, stat_sum6);
        end
    endtask

    task automatic test_reset_mid();
        beat(8'h01, 1, 0, 1);
        beat(8'h02, 0, 0, 1);
        beat(8'h03, 0, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        din_vld = 1'b0;
        din_sop = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (rec !== 21'h0) begin fails++; $display("FAIL rst_mid got %h exp %h", rec, 21'h0); end
        beat(8'h05, 1, 0, 1);
        beat(8'h06, 0, 1, 1);
        idle();
        exp_rec = {1'b1, 1'b0, 8'd2, 8'h0b, 3'b000};
        vectors++;
        if (rec !== exp_rec) begin fails++; $display("FAIL rst_clean got %h exp %h", rec, exp_rec); end
`ifdef PKT_STAT_CNT_EN
        vectors++;
        if (pkt_cnt !== 16'd1) begin fails++; $display("FAIL rst_cnt got %0d exp 1", pkt_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_orphan();
        test_truncate();
        test_back_to_back();
        test_timeout();
        test_overlength();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/pkt_stat.md
Name: pkt_stat

Overview:
- Downstream consumer of the byte-stream packet framer's output (din, sop, eop, vld).
- Delineates each packet and measures its length.
- Computes an 8-bit modular byte sum and flags framing errors.
- Emits one registered summary record per packet to the control/debug logic.

Parameters:
LEN_W, 8, width of stat_len; maximum reportable length is 2^LEN_W-1
MAX_LEN, 64, packets longer than this set the overlength error bit
TMO_CYC, 16, consecutive idle (vld=0) cycles inside a packet before the timeout abort; range 1..255

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
din  in  8  data byte, qualified by din_vld
din_sop  in  1  first byte of packet, qualified by din_vld
din_eop  in  1  last byte of packet, qualified by din_vld
din_vld  in  1  beat valid; no backpressure, every valid beat is consumed
stat_vld  out  1  one-cycle pulse, summary fields valid
stat_len  out  LEN_W  bytes in packet, including sop and eop beats
stat_sum  out  8  sum of all packet bytes mod 256
stat_err  out  3  bit0 = sop inside packet (truncated), bit1 = overlength, bit2 = timeout
drop_pls  out  1  one-cycle pulse, a valid beat was discarded

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - State goes to IDLE.
  - All outputs are 0; len/sum accumulators and gap counter are cleared.
  - A packet in progress is discarded with no report.
- States:
  - IDLE, waiting for sop.
  - RX, accumulating.
- IDLE:
  - vld&sop&!eop: load len=1, sum=din, gap=0, err=0; go to RX.
  - vld&sop&eop: single-byte packet; report len=1, sum=din, err=0; stay in IDLE.
  - vld&!sop: orphan beat; drop_pls=1 the next cycle; stay in IDLE.
- RX, plain beat (vld&!sop):
  - len+=1, saturating at 2^LEN_W-1.
  - sum+=din, mod 256.
  - gap=0.
  - If the updated len exceeds MAX_LEN, set err bit1 (sticky for the packet).
- RX, eop beat: the beat is included in the packet; report; go to IDLE.
- RX, vld&sop (new packet while one is open):
  - Report the open packet with err bit0, excluding the new beat.
  - Start a new packet with this beat (len=1, sum=din); stay in RX.
  - If that beat also carries eop: the truncated report still goes out, the single-byte packet is discarded, drop_pls=1, go to IDLE.
- RX, vld=0:
  - gap+=1.
  - When gap reaches TMO_CYC: report with err bit2, len/sum as accumulated so far; go to IDLE.
- Latency and pulse timing:
  - stat_vld/stat_* are registered and appear exactly 1 cycle after the terminating beat (or the timeout cycle).
  - stat_* hold their value until the next report; stat_vld is high for 1 cycle only.
  - Back-to-back packets can produce stat_vld on consecutive cycles.
- Priority within one cycle: rst > sop-in-packet > eop > plain beat > gap increment.

Optional Feature:
- Macro PKT_STAT_CNT_EN, when defined:
  - Adds output pkt_cnt[15:0]: count of reports with stat_err==0.
  - Increments in the same cycle stat_vld is asserted; wraps 0xFFFF->0; reset to 0.
- Without the macro: no port and no counter logic.

Decomposition:
- Shared package pkt_pkg holds:
  - State encodings IDLE=0, RX=1.
  - Error bit indices ERR_SOP=0, ERR_LEN=1, ERR_TMO=2.
  - Byte width 8.
- One sub-module, pkt_gap_tmr: gap counter with clear/inc/expire.
  - Inputs: clk, rst, clr, inc.
  - Output: expire, asserted combinationally when count==TMO_CYC-1 and inc=1.

Test Plan:
- Packet of 4 beats (0x01 sop, 0x02, 0x03, 0x04 eop), contiguous -> stat_vld 1 cycle after eop, len=4, sum=0x0A, err=0.
- Single beat 0xFF with sop&eop in IDLE -> next cycle len=1, sum=0xFF, err=0; a following orphan beat 0x55 (no sop) -> drop_pls pulse, no stat_vld.
- Packet 0x10 sop, 0x20, then 0x30 with sop (no eop), 0x40 eop -> first report len=2, sum=0x30, err=001; second report len=2, sum=0x70, err=000.
- sop 0x01, 0x02, then vld=0 for TMO_CYC=16 cycles -> report len=2, sum=0x03, err=100; a later eop beat without sop -> drop_pls.
- 70-byte packet of 0x01 (MAX_LEN=64) -> len=70, sum=0x46, err=010. With LEN_W=6, a 70-byte packet -> len saturates at 63.
- rst asserted for 1 cycle mid-packet after 3 beats, then a clean 2-byte packet -> no report for the aborted packet, then len=2; with PKT_STAT_CNT_EN, pkt_cnt=1.
